// File: rtl/vga_vram_scheduler.sv
// Single-port video RAM scheduler: fetches the next scan line into a line buffer during
// horizontal blanking, serves CPU accesses otherwise, and serialises 1-bpp pixels.
module vga_vram_scheduler #(
    parameter int WORDS_PER_LINE = 80,
    parameter int LINES          = 480,
    parameter int HACTIVE        = 1280,
    parameter int VTOTAL         = 525
) (
    input  logic        clk50_i,
    input  logic        reset_n_i,
    input  logic [10:0] hcount_i,
    input  logic [9:0]  vcount_i,
    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic [15:0] cpu_addr_i,
    input  logic [7:0]  cpu_wdata_i,
    output logic        cpu_ack_o,
    output logic [7:0]  cpu_rdata_o,
    output logic [15:0] ram_addr_o,
    output logic        ram_we_o,
    output logic [7:0]  ram_wdata_o,
    input  logic [7:0]  ram_rdata_i,
    output logic        pixel_on_o,
    output logic        fetch_busy_o
);
    // state   | meaning
    // S_IDLE  | RAM free: a fetch may start or a CPU access may be granted and issued
    // S_CPU   | CPU access completing: ack (and read data) this cycle, never re-granted
    // S_FETCH | line fetch owns the RAM: words 1..79 issue, final cycle captures word 79
    typedef enum logic [1:0] {S_IDLE, S_CPU, S_FETCH} state_e;

    localparam logic [10:0] H_ACT     = 11'(HACTIVE);
    localparam logic [9:0]  V_ACT     = 10'(LINES);
    localparam logic [9:0]  V_FETCH   = 10'(LINES - 1);
    localparam logic [9:0]  V_LAST    = 10'(VTOTAL - 1);
    localparam logic [15:0] RAM_TOP   = 16'(WORDS_PER_LINE * LINES);
    localparam logic [6:0]  K_LAST    = 7'(WORDS_PER_LINE - 1);
    localparam logic [6:0]  K_END     = 7'(WORDS_PER_LINE);

    state_e      state_q, state_d;
    logic [6:0]  fetch_k_q, fetch_k_d;
    logic [15:0] line_base_q, line_base_d;
    logic        rd_fetch_q, rd_fetch_d;    // tag: data returning now belongs to the line buffer
    logic [6:0]  rd_idx_q, rd_idx_d;
    logic        cpu_rd_q, cpu_rd_d;
    logic        line_valid_q, line_valid_d;
    logic        pixel_q, pixel_d;
    logic [7:0]  linebuf_q [WORDS_PER_LINE];

    logic        fetch_start, grant, cpu_in_range, pix_active;
    logic [9:0]  line_sel, pix_x;
    logic [15:0] line_ext, start_base;
    logic [6:0]  pix_idx;
    logic [7:0]  pix_byte;

    // Nothing issues while reset is held, so the RAM bus stays quiet during reset.
    assign fetch_start  = reset_n_i && (state_q != S_FETCH) && (hcount_i == H_ACT) &&
                          ((vcount_i < V_FETCH) || (vcount_i == V_LAST));
    assign grant        = reset_n_i && (state_q == S_IDLE) && cpu_req_i && !fetch_start;
    assign cpu_in_range = cpu_addr_i < RAM_TOP;
    assign line_sel     = (vcount_i == V_LAST) ? 10'd0 : vcount_i + 10'd1;
    assign line_ext     = {6'b0, line_sel};
    assign start_base   = (line_ext << 6) + (line_ext << 4);

    assign pix_active = (hcount_i < H_ACT) && (vcount_i < V_ACT);
    assign pix_x      = hcount_i[10:1];
    assign pix_idx    = pix_active ? pix_x[9:3] : 7'd0;
    assign pix_byte   = linebuf_q[pix_idx];

    always_ff @(posedge clk50_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= S_IDLE;
            fetch_k_q    <= '0;
            line_base_q  <= '0;
            rd_fetch_q   <= 1'b0;
            rd_idx_q     <= '0;
            cpu_rd_q     <= 1'b0;
            line_valid_q <= 1'b0;
            pixel_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_k_q    <= fetch_k_d;
            line_base_q  <= line_base_d;
            rd_fetch_q   <= rd_fetch_d;
            rd_idx_q     <= rd_idx_d;
            cpu_rd_q     <= cpu_rd_d;
            line_valid_q <= line_valid_d;
            pixel_q      <= pixel_d;
        end
    end

    always_ff @(posedge clk50_i) begin
        if (rd_fetch_q) linebuf_q[rd_idx_q] <= ram_rdata_i;
    end

    always_comb begin
        state_d      = state_q;
        fetch_k_d    = fetch_k_q;
        line_base_d  = line_base_q;
        rd_fetch_d   = 1'b0;
        rd_idx_d     = fetch_k_q;
        cpu_rd_d     = 1'b0;
        line_valid_d = line_valid_q || (rd_fetch_q && (rd_idx_q == K_LAST));
        pixel_d      = pix_active && line_valid_q && pix_byte[3'd7 - pix_x[2:0]];
        case (state_q)
            S_IDLE, S_CPU: begin
                if (fetch_start) begin
                    state_d     = S_FETCH;
                    fetch_k_d   = 7'd1;
                    line_base_d = start_base;
                    rd_fetch_d  = 1'b1;
                    rd_idx_d    = 7'd0;
                end else if (grant) begin
                    state_d  = S_CPU;
                    cpu_rd_d = !cpu_we_i && cpu_in_range;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                if (fetch_k_q == K_END) begin
                    state_d = S_IDLE;
                end else begin
                    fetch_k_d  = fetch_k_q + 7'd1;
                    rd_fetch_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ram_addr_o  = '0;
        ram_we_o    = 1'b0;
        ram_wdata_o = '0;
        if (fetch_start) begin
            ram_addr_o = start_base;
        end else if ((state_q == S_FETCH) && (fetch_k_q != K_END)) begin
            ram_addr_o = line_base_q + {9'b0, fetch_k_q};
        end else if (grant && cpu_in_range) begin
            ram_addr_o  = cpu_addr_i;
            ram_we_o    = cpu_we_i;
            ram_wdata_o = cpu_wdata_i;
        end
        fetch_busy_o = fetch_start || (state_q == S_FETCH);
        cpu_ack_o    = (state_q == S_CPU);
        cpu_rdata_o  = cpu_rd_q ? ram_rdata_i : 8'h00;
        pixel_on_o   = pixel_q;
    end

endmodule
